// File: rtl/periph_pkg.sv
// Shared types for the two-requester peripheral arbiter.
package periph_pkg;

  // Access sequencer states: one arbitration slot, one bus cycle, one response cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Identifies which requester owns the current or last access.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is chosen; the history register starts out pointing at M1 so
// M0 wins the first tie after reset.
module rr_arb2
  import periph_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       valid,
  output req_id_e    winner
);

  req_id_e last_q;
  req_id_e last_d;

  // Pick a winner from the live request lines and the grant history.
  always_comb begin
    valid  = req[0] | req[1];
    winner = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = (last_q == M1) ? M0 : M1;
      default: winner = M0;
    endcase
  end

  // Remember the winner only when the sequencer actually commits to it.
  always_comb begin
    if (update && valid) begin
      last_d = winner;
    end else begin
      last_d = last_q;
    end
  end

  // Grant history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/periph_arbiter.sv
// Shares one peripheral bus between two requesters. Each access takes an
// arbitration cycle (IDLE or RESP), one ACCESS cycle carrying the bus
// strobe and grant, and a RESP cycle carrying the completion pulse.
module periph_arbiter
  import periph_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e            state_q, state_d;
  req_id_e           win_q, win_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_re_q, bus_re_d;
  logic              m0_gnt_q, m0_gnt_d;
  logic              m1_gnt_q, m1_gnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              arb_en;
  logic              arb_valid;
  req_id_e           arb_winner;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_req, m0_req}),
    .update (arb_en),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Sequencer next state plus the registered bus/grant/response values for
  // the following cycle; strobes and pulses default low, rdata holds.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    bus_addr_d  = {ADDR_W{1'b0}};
    bus_wdata_d = {DATA_W{1'b0}};
    bus_we_d    = 1'b0;
    bus_re_d    = 1'b0;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    arb_en      = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        arb_en = 1'b1;
        if (arb_valid) begin
          state_d = ACCESS;
          win_d   = arb_winner;
          if (arb_winner == M1) begin
            bus_addr_d  = m1_addr;
            bus_wdata_d = m1_wdata;
            bus_we_d    = m1_we;
            bus_re_d    = ~m1_we;
            m1_gnt_d    = 1'b1;
          end else begin
            bus_addr_d  = m0_addr;
            bus_wdata_d = m0_wdata;
            bus_we_d    = m0_we;
            bus_re_d    = ~m0_we;
            m0_gnt_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Peripheral read data is combinational, so capture it as the
        // ACCESS cycle closes; writes complete with zero data.
        state_d = RESP;
        if (win_q == M1) begin
          m1_rvalid_d = 1'b1;
          m1_rdata_d  = bus_we_q ? {DATA_W{1'b0}} : bus_rdata;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_rdata_d  = bus_we_q ? {DATA_W{1'b0}} : bus_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset cancels any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_q       <= M0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_wdata_q <= {DATA_W{1'b0}};
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= {DATA_W{1'b0}};
      m1_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// Bench for periph_arbiter: directed cases with literal expectations, then
// randomized traffic checked every cycle against a timeline model.
module tb_periph_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_re;

  logic        rq_req [2];
  logic        rq_we  [2];
  logic [31:0] rq_addr[2];
  logic [31:0] rq_wdat[2];
  logic        force_en;
  logic [31:0] force_val;

  int vectors     = 0;
  int miscompares = 0;

  // Model: an access decided at an edge occupies the next cycle; its
  // response shows in the cycle after that.
  typedef struct packed {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;
  logic        acc_cur_v;
  acc_t        acc_cur;
  logic        rsp_cur_v;
  logic        rsp_cur_who;
  logic [31:0] mdl_rdata[2];
  logic        last_win;
  logic [1:0]  pend;
  int          waitc[2];

  assign m0_req   = rq_req[0];
  assign m1_req   = rq_req[1];
  assign m0_we    = rq_we[0];
  assign m1_we    = rq_we[1];
  assign m0_addr  = rq_addr[0];
  assign m1_addr  = rq_addr[1];
  assign m0_wdata = rq_wdat[0];
  assign m1_wdata = rq_wdat[1];

  function automatic logic [31:0] periph_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign bus_rdata = force_en ? force_val : periph_fn(bus_addr);

  periph_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc_cur_v    = 1'b0;
    acc_cur      = '0;
    rsp_cur_v    = 1'b0;
    rsp_cur_who  = 1'b0;
    mdl_rdata[0] = 32'h0;
    mdl_rdata[1] = 32'h0;
    last_win     = 1'b1;
    pend         = 2'b00;
    waitc[0]     = 0;
    waitc[1]     = 0;
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    rq_req[i]  = r;
    rq_we[i]   = w;
    rq_addr[i] = a;
    rq_wdat[i] = d;
  endtask

  // Advance the model across the coming edge using the inputs now driven.
  task automatic model_step();
    acc_t nxt;
    logic nxt_v;
    logic who;
    nxt   = '0;
    nxt_v = 1'b0;
    rsp_cur_v   = acc_cur_v;
    rsp_cur_who = acc_cur.who;
    if (acc_cur_v)
      mdl_rdata[acc_cur.who] = acc_cur.we ? 32'h0 : (force_en ? force_val : periph_fn(acc_cur.addr));
    if (!acc_cur_v && (rq_req[0] || rq_req[1])) begin
      if (rq_req[0] && rq_req[1]) who = ~last_win;
      else                        who = rq_req[1];
      last_win  = who;
      nxt_v     = 1'b1;
      nxt.who   = who;
      nxt.we    = rq_we[who];
      nxt.addr  = rq_addr[who];
      nxt.wdata = rq_wdat[who];
    end
    acc_cur_v = nxt_v;
    acc_cur   = nxt;
  endtask

  // Compare every DUT output for the current cycle against the model.
  task automatic check_cycle();
    logic [1:0]  eg, ev;
    logic        ewe, ere, g;
    logic [31:0] ea, ed;
    eg = 2'b00; ev = 2'b00; ewe = 1'b0; ere = 1'b0; ea = 32'h0; ed = 32'h0;
    if (acc_cur_v) begin
      eg[acc_cur.who] = 1'b1;
      ewe = acc_cur.we;
      ere = ~acc_cur.we;
      ea  = acc_cur.addr;
      ed  = acc_cur.wdata;
    end
    if (rsp_cur_v) ev[rsp_cur_who] = 1'b1;
    chk("m0_gnt", m0_gnt, eg[0]);
    chk("m1_gnt", m1_gnt, eg[1]);
    chk("m0_rvalid", m0_rvalid, ev[0]);
    chk("m1_rvalid", m1_rvalid, ev[1]);
    chk("m0_rdata", m0_rdata, mdl_rdata[0]);
    chk("m1_rdata", m1_rdata, mdl_rdata[1]);
    chk("bus_we", bus_we, ewe);
    chk("bus_re", bus_re, ere);
    chk("bus_addr", bus_addr, ea);
    chk("bus_wdata", bus_wdata, ed);
    chk("gnt_exclusive", m0_gnt & m1_gnt, 32'h0);
    chk("rvalid_exclusive", m0_rvalid & m1_rvalid, 32'h0);
    chk("strobe_exclusive", bus_we & bus_re, 32'h0);
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        g = (i == 0) ? m0_gnt : m1_gnt;
        waitc[i]++;
        if (g) begin
          vectors++;
          if (waitc[i] > 4) begin
            miscompares++;
            $display("FAIL starve_m%0d: waited %0d cycles, expected at most 4", i, waitc[i]);
          end
        end else if (waitc[i] == 8) begin
          vectors++;
          miscompares++;
          $display("FAIL starve_timeout_m%0d: no gnt after %0d cycles, expected at most 4", i, waitc[i]);
        end
      end
    end
  endtask

  // Requesters: hold a pending request until the model grants it, sometimes
  // abandon it, otherwise issue fresh random traffic.
  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (pend[i] && acc_cur_v && (acc_cur.who == i[0])) pend[i] = 1'b0;
      if (pend[i]) begin
        if ($urandom_range(0, 15) == 0) begin
          rq_req[i] = 1'b0;
          pend[i]   = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        set_req(i, 1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
        pend[i]  = 1'b1;
        waitc[i] = 0;
      end else begin
        rq_req[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk);
    check_cycle();
    set_req(0, r0, w0, a0, d0);
    set_req(1, r1, w1, a1, d1);
    model_step();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    force_en  = 1'b0;
    force_val = 32'h0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {m1_gnt, m0_gnt}, 32'h0);
    chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_strobes", {bus_we, bus_re}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // m0 read: gnt + bus_re at N+1, rvalid with peripheral data at N+2
    force_en  = 1'b1;
    force_val = 32'h12345678;
    cycle(1'b1, 1'b0, 32'ha0000000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycle();
    chk("rd_gnt", m0_gnt, 32'h1);
    chk("rd_re", bus_re, 32'h1);
    chk("rd_addr", bus_addr, 32'ha0000000);
    idle_cycle();
    chk("rd_rvalid", m0_rvalid, 32'h1);
    chk("rd_rdata", m0_rdata, 32'h12345678);
    chk("rd_strobe_gone", bus_re, 32'h0);
    force_en = 1'b0;

    // m1 write: one bus_we cycle, completion with zero data
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'ha0000004, 32'hdeadbeef);
    idle_cycle();
    chk("wr_gnt", m1_gnt, 32'h1);
    chk("wr_we", bus_we, 32'h1);
    chk("wr_addr", bus_addr, 32'ha0000004);
    chk("wr_wdata", bus_wdata, 32'hdeadbeef);
    idle_cycle();
    chk("wr_rvalid", m1_rvalid, 32'h1);
    chk("wr_rdata", m1_rdata, 32'h0);
    chk("wr_we_one_cycle", bus_we, 32'h0);
    idle_cycle();

    // Sustained contention from reset alternates m0,m1,m0,m1
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b0, 32'h00000100, 32'h0, 1'b1, 1'b1, 32'h00000200, 32'h55aa55aa);
      if (k % 2 == 0) begin
        chk("tie_m0_gnt", m0_gnt, ((k / 2) % 2 == 1) ? 32'h1 : 32'h0);
        chk("tie_m1_gnt", m1_gnt, ((k / 2) % 2 == 0) ? 32'h1 : 32'h0);
      end
    end
    repeat (3) idle_cycle();

    // Reset pulsed during ACCESS: strobes drop immediately, no rvalid
    cycle(1'b1, 1'b0, 32'ha0000010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    chk("mid_pre_gnt", m0_gnt, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_re_drop", bus_re, 32'h0);
    chk("mid_gnt_drop", m0_gnt, 32'h0);
    chk("mid_addr_drop", bus_addr, 32'h0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    chk("mid_no_rvalid", m0_rvalid, 32'h0);
    idle_cycle();
    force_en  = 1'b1;
    force_val = 32'hcafef00d;
    cycle(1'b1, 1'b0, 32'ha0000020, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycle();
    idle_cycle();
    chk("post_rst_rvalid", m0_rvalid, 32'h1);
    chk("post_rst_rdata", m0_rdata, 32'hcafef00d);
    force_en = 1'b0;
    idle_cycle();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check_cycle();
      drive_random();
      model_step();
    end
    repeat (4) idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, requester and bus address width.
REQ-002 Parameter DATA_W, default 32, requester and bus data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assert, synchronous release, active-low.
REQ-005 m0_req, m1_req  input  1 each  requester N access request; held high with stable payload until m*_gnt.
REQ-006 m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  input  ADDR_W each  access address.
REQ-008 m0_wdata, m1_wdata  input  DATA_W each  write data.
REQ-009 m0_gnt, m1_gnt  output  1 each  one-cycle pulse; request consumed this cycle.
REQ-010 m0_rvalid, m1_rvalid  output  1 each  one-cycle completion pulse, for reads and writes.
REQ-011 m0_rdata, m1_rdata  output  DATA_W each  read data, valid with rvalid; 0 for writes.
REQ-012 bus_addr  output  ADDR_W  shared peripheral address.
REQ-013 bus_wdata  output  DATA_W  shared write data.
REQ-014 bus_we, bus_re  output  1 each  write / read strobes; mutually exclusive.
REQ-015 bus_rdata  input  DATA_W  combinational read data returned by the peripherals in the same cycle as bus_re.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; exactly one bus access per ACCESS cycle.
REQ-017 IDLE or RESP with any req high -> ACCESS next cycle, winner registered; no req -> IDLE.
REQ-018 ACCESS -> RESP unconditionally, after exactly one cycle.
REQ-019 Arbitration: single requester wins; both requesting -> winner is the requester not granted last; last_grant resets to m1, so m0 wins the first tie.
REQ-020 In ACCESS: bus_addr/bus_wdata = winner payload, bus_we = winner we, bus_re = ~winner we, winner gnt = 1; all registered outputs.
REQ-021 Outside ACCESS: bus_we = bus_re = 0, bus_addr = 0, bus_wdata = 0, both gnt = 0.
REQ-022 bus_rdata sampled at the end of the ACCESS cycle into the winner's rdata register; writes load 0.
REQ-023 Winner rvalid = 1 in RESP; loser rvalid = 0; rdata holds until that requester's next completion.
REQ-024 Latency: req seen in cycle N (IDLE) -> bus strobe and gnt in N+1 -> rvalid in N+2.
REQ-025 Back-to-back: arbitration in RESP allows ACCESS every second cycle; sustained contention alternates m0, m1.
REQ-026 A requester dropping req before its gnt is legal; it is simply not served; a req deasserted during ACCESS does not abort the access.
REQ-027 Never more than one gnt or one rvalid high in any cycle.

Reset
REQ-028 rst low forces immediately: state IDLE, last_grant = m1, all outputs 0, rdata registers 0.
REQ-029 Reset during ACCESS or RESP cancels the access and suppresses its rvalid; first access after release starts from IDLE.

Structure
REQ-030 Shared package periph_pkg holds the state enum (IDLE, ACCESS, RESP) and requester-ID type.
REQ-031 Sub-module rr_arb2 (2-input round-robin, last_grant register) is instantiated once; the FSM and datapath stay in periph_arbiter.

Verification
REQ-032 m0 read addr 0xa0000000, bus_rdata 0x12345678 -> gnt at N+1 with bus_re = 1; m0_rvalid at N+2 with m0_rdata = 0x12345678.
REQ-033 m1 write addr 0xa0000004 data 0xdeadbeef -> bus_we = 1 with matching addr and data for one cycle; m1_rvalid at N+2 with m1_rdata = 0.
REQ-034 m0 and m1 request together from reset -> m0 granted first, m1 two cycles later; 4 held requests alternate 0,1,0,1.
REQ-035 rst pulsed low during ACCESS -> strobes drop asynchronously; no rvalid; next request completes normally.
REQ-036 Random req/we/addr for 10k cycles -> scoreboard checks mutual exclusion of gnt and rvalid, 2-cycle latency, and no starvation (wait of at most 4 cycles under contention).
